cacheline_adaptor: RTL and testbench

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cacheline_adaptor.sv | 101 ++++++++++
 tb/tb_cacheline_adaptor.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// Bridges 256-bit line requests from the cache arbiter to a 4 x 64-bit burst memory port.
// All outputs are registered; a DONE cycle returns a one-cycle resp_o before going idle.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst_n,
  // Arbiter side
  input  logic         read_i,
  input  logic         write_i,
  input  logic [31:0]  address_i,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  output logic         resp_o,
  // Memory side
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e         state_q;
  logic [1:0]     k_q;
  logic [1:0]     k_inc;
  logic [255:0]   line_q;
  logic           unused_addr_bits;

  assign k_inc = k_q + 2'd1;
  // Line-offset bits never reach memory; the burst is always line aligned.
  assign unused_addr_bits = ^address_i[4:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      k_q       <= 2'd0;
      line_q    <= '0;
      line_o    <= '0;
      resp_o    <= 1'b0;
      burst_o   <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      case (state_q)
        StIdle: begin
          // A simultaneous read and write resolves to the read.
          if (read_i) begin
            state_q   <= StRead;
            k_q       <= 2'd0;
            read_o    <= 1'b1;
            address_o <= {address_i[31:5], 5'b0};
          end else if (write_i) begin
            state_q   <= StWrite;
            k_q       <= 2'd0;
            line_q    <= line_i;
            write_o   <= 1'b1;
            address_o <= {address_i[31:5], 5'b0};
            burst_o   <= line_i[63:0];
          end
        end
        StRead: begin
          if (resp_i) begin
            line_o[{k_q, 6'b0} +: 64] <= burst_i;
            k_q <= k_inc;
            if (k_q == 2'd3) begin
              state_q   <= StDone;
              read_o    <= 1'b0;
              address_o <= '0;
              resp_o    <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (resp_i) begin
            k_q <= k_inc;
            if (k_q == 2'd3) begin
              state_q   <= StDone;
              write_o   <= 1'b0;
              address_o <= '0;
              burst_o   <= '0;
              resp_o    <= 1'b1;
            end else begin
              // Present the next beat so it is stable for the following strobe.
              burst_o <= line_q[{k_inc, 6'b0} +: 64];
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst_n;
  logic         read_i;
  logic         write_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int checks = 0;
  int errors = 0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_i    (read_i),
    .write_i   (write_i),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Transaction-level model: kind 0 = none, 1 = read burst, 2 = write burst.
  int           m_kind  = 0;
  int           m_beats = 0;
  bit           m_done  = 1'b0;
  logic [31:0]  m_addr  = '0;
  logic [255:0] m_wline = '0;
  logic [255:0] m_line  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kind  <= 0;
      m_beats <= 0;
      m_done  <= 1'b0;
      m_addr  <= '0;
      m_wline <= '0;
      m_line  <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_kind == 0) begin
      if (read_i || write_i) begin
        m_kind  <= read_i ? 1 : 2;
        m_beats <= 0;
        m_addr  <= address_i & 32'hFFFF_FFE0;
        if (!read_i) m_wline <= line_i;
      end
    end else if (resp_i) begin
      if (m_kind == 1) m_line[64*m_beats +: 64] <= burst_i;
      m_beats <= m_beats + 1;
      if (m_beats == 3) begin
        m_kind <= 0;
        m_done <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] exp_burst;
    exp_burst = (m_kind == 2) ? m_wline[64*m_beats +: 64] : 64'd0;
    chk1("cmp_read_o", read_o, m_kind == 1);
    chk1("cmp_write_o", write_o, m_kind == 2);
    chk1("cmp_resp_o", resp_o, m_done);
    chk("cmp_address_o", 256'(address_o), 256'((m_kind != 0) ? m_addr : 32'd0));
    chk("cmp_burst_o", 256'(burst_o), 256'(exp_burst));
    chk("cmp_line_o", line_o, m_line);
  end

  logic [255:0] last_rd;

  // Read burst; gap idle strobes follow the first beat; both also raises write_i.
  task automatic do_read(input logic [31:0] a, input logic [255:0] beats, input int gap,
                         input bit both);
    read_i    = 1'b1;
    write_i   = both;
    address_i = a;
    line_i    = {8{32'hDEAD_BEEF}};
    resp_i    = 1'b0;
    step();
    chk("rd_address_o", 256'(address_o), 256'({a[31:5], 5'b0}));
    chk1("rd_read_o_first", read_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      resp_i    = 1'b1;
      burst_i   = beats[64*i +: 64];
      address_i = ~a;
      step();
      chk1("rd_write_o_low", write_o, 1'b0);
      if (i < 3) begin
        chk1("rd_no_early_resp", resp_o, 1'b0);
        chk1("rd_read_o_held", read_o, 1'b1);
      end
      if (i == 0) begin
        for (int g = 0; g < gap; g++) begin
          resp_i  = 1'b0;
          burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
          step();
          chk1("gap_read_o", read_o, 1'b1);
          chk1("gap_no_resp", resp_o, 1'b0);
        end
      end
    end
    chk1("rd_resp_o", resp_o, 1'b1);
    chk1("rd_read_o_done", read_o, 1'b0);
    chk("rd_line_o", line_o, beats);
    read_i  = 1'b0;
    write_i = 1'b0;
    resp_i  = 1'b0;
    step();
    chk1("rd_resp_one_cycle", resp_o, 1'b0);
    last_rd = beats;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [255:0] l);
    write_i   = 1'b1;
    read_i    = 1'b0;
    address_i = a;
    line_i    = l;
    resp_i    = 1'b0;
    step();
    chk("wr_address_o", 256'(address_o), 256'({a[31:5], 5'b0}));
    for (int i = 0; i < 4; i++) begin
      chk("wr_burst_o", 256'(burst_o), 256'(l[64*i +: 64]));
      chk1("wr_write_o", write_o, 1'b1);
      chk1("wr_no_early_resp", resp_o, 1'b0);
      resp_i = 1'b1;
      line_i = ~l;
      step();
    end
    chk1("wr_write_o_done", write_o, 1'b0);
    chk1("wr_resp_o", resp_o, 1'b1);
    chk("wr_burst_o_idle", 256'(burst_o), 256'(0));
    chk("wr_line_o_kept", line_o, last_rd);
    write_i = 1'b0;
    resp_i  = 1'b0;
    step();
    chk1("wr_resp_one_cycle", resp_o, 1'b0);
  endtask

  logic [255:0] l1;
  logic [255:0] l2;
  logic [255:0] wl;
  bit           req_active;

  initial begin
    rst_n     = 1'b0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = '0;
    line_i    = '0;
    burst_i   = '0;
    resp_i    = 1'b0;
    last_rd   = '0;
    l1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    l2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
          64'h0F0F_0F0F_F0F0_F0F0, 64'hCAFE_F00D_1234_5678};
    wl = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    step();
    step();
    chk1("reset_read_o", read_o, 1'b0);
    chk1("reset_write_o", write_o, 1'b0);
    chk1("reset_resp_o", resp_o, 1'b0);
    chk("reset_line_o", line_o, 256'd0);
    chk("reset_address_o", 256'(address_o), 256'd0);

    // First request raised together with reset release.
    rst_n = 1'b1;
    do_read(32'h0000_1234, l1, 0, 1'b0);
    do_write(32'h0000_2048, wl);
    do_read(32'h0000_1234, l1, 2, 1'b0);
    do_read(32'hABCD_EF7F, l2, 0, 1'b1);

    // Stray strobes while idle.
    for (int i = 0; i < 3; i++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      step();
      chk("stray_line_o", line_o, l2);
      chk1("stray_read_o", read_o, 1'b0);
      chk("stray_address_o", 256'(address_o), 256'd0);
    end
    resp_i = 1'b0;

    // Reset after two beats abandons the read.
    read_i    = 1'b1;
    address_i = 32'h8000_0040;
    step();
    resp_i  = 1'b1;
    burst_i = {16{4'h5}};
    step();
    burst_i = {16{4'h6}};
    step();
    rst_n  = 1'b0;
    read_i = 1'b0;
    resp_i = 1'b0;
    #1;
    chk1("rst_read_o", read_o, 1'b0);
    chk1("rst_resp_o", resp_o, 1'b0);
    chk("rst_line_o", line_o, 256'd0);
    chk("rst_address_o", 256'(address_o), 256'd0);
    step();
    chk1("rst_no_resp", resp_o, 1'b0);
    step();
    rst_n   = 1'b1;
    last_rd = '0;
    step();
    chk1("post_rst_no_resp", resp_o, 1'b0);
    do_read(32'h0000_1234, l1, 0, 1'b0);

    // Randomized traffic; the per-cycle compare process does the checking.
    req_active = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (req_active && resp_o) begin
        if ($urandom_range(7) != 0) begin
          read_i     = 1'b0;
          write_i    = 1'b0;
          req_active = 1'b0;
        end
      end else if (!req_active && $urandom_range(2) == 0) begin
        case ($urandom_range(3))
          0, 1:    begin read_i = 1'b1; write_i = 1'b0; end
          2:       begin read_i = 1'b0; write_i = 1'b1; end
          default: begin read_i = 1'b1; write_i = 1'b1; end
        endcase
        address_i  = $urandom;
        line_i     = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
        req_active = 1'b1;
      end else if (req_active && $urandom_range(3) == 0) begin
        address_i = $urandom;
        line_i    = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
      end
      resp_i  = ($urandom_range(2) != 0);
      burst_i = {$urandom, $urandom};
      if ($urandom_range(499) == 0) begin
        rst_n      = 1'b0;
        read_i     = 1'b0;
        write_i    = 1'b0;
        req_active = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end

    read_i  = 1'b0;
    write_i = 1'b0;
    resp_i  = 1'b0;
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
